multi_level_delay: RTL and testbench
====================================

Name: multi_level_delay

Overview:
Multi-channel, parametrised successor to the single-channel enable delay element.
- Each channel delays the rising edge of its level enable by a programmable assert delay.
- Each channel can also delay the falling edge by a separate deassert delay, which acts as a glitch filter and stretcher.
- Delay values are latched per transition, so on-the-fly changes are safe and never produce unpredictable results.
- Sits in the controller's timing/sequencing logic, for example tCKE/tXP-style enable gating, with one channel per gated control.

Parameters:
- NUM_CH, 4: number of independent channels.
- CNT_W, 16: width of each delay value and counter.
- DEASSERT_EN, 1: 1 enables delayed deassertion; 0 deasserts immediately and ignores deassert_dly.

Ports:
- clk_core  in  1  core clock; the only clock.
- rst_core  in  1  reset, asynchronous, active-high.
- enable  in  NUM_CH  per-channel level request; synchronous to clk_core.
- assert_dly  in  NUM_CH*CNT_W  per-channel assert delay in cycles; channel i occupies [i*CNT_W +: CNT_W].
- deassert_dly  in  NUM_CH*CNT_W  per-channel deassert delay in cycles; same packing as assert_dly.
- delayed_en  out  NUM_CH  delayed, registered enable.
- rise_pulse  out  NUM_CH  one-cycle pulse on the first cycle delayed_en is 1.
- fall_pulse  out  NUM_CH  one-cycle pulse on the first cycle delayed_en is 0 after being 1.
- busy  out  NUM_CH  channel is counting (RISE or FALL state).

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset: all state goes to IDLE; counters and latched delays go to 0; delayed_en, rise_pulse, fall_pulse and busy are all 0.
- Reset asserted mid-count: the channel clears immediately and no pulse is emitted.
- Channels are fully independent. Every output is registered; there is no combinational path from enable to any output.
- Per-channel FSM states are IDLE, RISE, ON and FALL.
- delayed_en = 1 in ON and FALL. busy = 1 in RISE and FALL.
- IDLE, enable sampled 1 at edge t0:
  - Latch D = assert_dly[i] and clear the counter.
  - If D == 0: go to ON and set rise_pulse.
  - Otherwise: go to RISE.
- RISE:
  - enable sampled 0: go to IDLE, clear the counter, no pulse (abort).
  - Otherwise, if count == D-1: go to ON and set rise_pulse.
  - Otherwise: count += 1.
- Net rise latency: delayed_en is 1 after edge t0+D, i.e. D+1 cycles after enable rises.
- ON, enable sampled 0:
  - If DEASSERT_EN == 0, or the latched E = deassert_dly[i] is 0: go to IDLE and set fall_pulse.
  - Otherwise: latch E, clear the counter, go to FALL.
- FALL:
  - enable sampled 1: go back to ON, clear the counter, no pulse. This is the glitch filter; delayed_en stays 1 throughout.
  - Otherwise, if count == E-1: go to IDLE and set fall_pulse.
  - Otherwise: count += 1.
- Net fall latency: delayed_en is 0 after edge t1+E, where t1 is the first edge sampling enable = 0.
- Pulses are high for exactly one cycle and are never asserted in the same cycle as each other.
- Width and arithmetic rules:
  - The counter is CNT_W bits and is compared against latched D-1 (or E-1), computed only when the latched value is at least 1.
  - The maximum count is 2^CNT_W-2, so the counter never wraps.
  - A delay of all-ones (2^CNT_W-1) is legal.
- Input changes: changes to assert_dly or deassert_dly while a channel is in RISE, FALL or ON have no effect until the next latch point.

Decomposition:
- Package level_delay_pkg holds:
  - typedef enum logic [1:0] ld_state_e {LD_IDLE, LD_RISE, LD_ON, LD_FALL};
  - the default CNT_W localparam.
- Sub-module level_delay_chan implements one channel (FSM, counter, latched delay, pulses).
- multi_level_delay is the generate wrapper that slices the packed delay buses, instantiating NUM_CH copies of level_delay_chan.

Test Plan:
- Reset behaviour: hold rst_core 1 with enable = 4'hF → all outputs 0. Release reset, then enable ch0 with assert_dly = 0 → delayed_en[0] = 1 and rise_pulse[0] = 1 one cycle after enable.
- Assert delay: ch1 with assert_dly = 5, enable held high → delayed_en[1] rises exactly 6 cycles after enable rises; busy[1] = 1 for 5 cycles; rise_pulse[1] is a single cycle.
- Abort: ch2 with assert_dly = 10, enable high for 4 cycles then low → delayed_en[2] and rise_pulse[2] never assert; busy[2] drops 1 cycle after enable falls.
- Deassert delay and glitch filter: ch3 with deassert_dly = 3 in ON.
  - Enable low for 2 cycles then high → delayed_en[3] stays 1 and no fall_pulse.
  - Enable low for 4+ cycles → delayed_en[3] drops 4 cycles after enable falls, together with fall_pulse[3].
- On-the-fly change: assert_dly changed from 8 to 2 at cycle 3 of a RISE count → rise still occurs at 9 cycles. The next enable cycle uses 2, giving 3 cycles.
- Immediate deassert and reset: with DEASSERT_EN = 0, deassert_dly = 7 → delayed_en drops 1 cycle after enable falls. Separately, rst_core pulsed mid-FALL → immediate 0 on all outputs, no fall_pulse.

Source files
------------

// File: rtl/level_delay_pkg.sv
// Shared types and defaults for the multi-channel level enable delay.
package level_delay_pkg;

    localparam int LD_CNT_W = 16;

    typedef enum logic [1:0] {LD_IDLE, LD_RISE, LD_ON, LD_FALL} ld_state_e;

endpackage

// File: rtl/level_delay_chan.sv
// One channel: delays the rising edge of enable by D cycles and, optionally,
// the falling edge by E cycles (glitch filter / stretcher).
module level_delay_chan
    import level_delay_pkg::*;
#(
    parameter int CNT_W       = LD_CNT_W,
    parameter bit DEASSERT_EN = 1'b1
) (
    input  logic             clk_core,
    input  logic             rst_core,
    input  logic             enable,
    input  logic [CNT_W-1:0] assert_dly,
    input  logic [CNT_W-1:0] deassert_dly,
    output logic             delayed_en,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             busy
);

    ld_state_e        state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] lat, lat_nxt;
    logic [CNT_W-1:0] lat_m1;
    logic             rise_nxt, fall_nxt;
    logic [CNT_W-1:0] fall_dly;

    // Only meaningful in RISE/FALL, where the latched delay is at least 1.
    assign lat_m1   = (lat != '0) ? lat - CNT_W'(1) : '0;
    assign fall_dly = DEASSERT_EN ? deassert_dly : '0;

    always_ff @(posedge clk_core or posedge rst_core) begin
        if (rst_core) begin
            state      <= LD_IDLE;
            cnt        <= '0;
            lat        <= '0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            lat        <= lat_nxt;
            rise_pulse <= rise_nxt;
            fall_pulse <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_nxt   = lat;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        unique case (state)
            LD_IDLE: begin
                if (enable) begin
                    lat_nxt = assert_dly;
                    cnt_nxt = '0;
                    if (assert_dly == '0) begin
                        state_nxt = LD_ON;
                        rise_nxt  = 1'b1;
                    end else begin
                        state_nxt = LD_RISE;
                    end
                end
            end
            LD_RISE: begin
                if (!enable) begin
                    state_nxt = LD_IDLE;
                    cnt_nxt   = '0;
                end else if (cnt == lat_m1) begin
                    state_nxt = LD_ON;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            LD_ON: begin
                if (!enable) begin
                    if (fall_dly == '0) begin
                        state_nxt = LD_IDLE;
                        fall_nxt  = 1'b1;
                    end else begin
                        lat_nxt   = fall_dly;
                        cnt_nxt   = '0;
                        state_nxt = LD_FALL;
                    end
                end
            end
            LD_FALL: begin
                // A re-assert during the count cancels the fall; output never drops.
                if (enable) begin
                    state_nxt = LD_ON;
                    cnt_nxt   = '0;
                end else if (cnt == lat_m1) begin
                    state_nxt = LD_IDLE;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = LD_IDLE;
        endcase
    end

    assign delayed_en = (state == LD_ON) || (state == LD_FALL);
    assign busy       = (state == LD_RISE) || (state == LD_FALL);

endmodule

// File: rtl/multi_level_delay.sv
// NUM_CH independent level enable delay channels sharing one clock.
module multi_level_delay
    import level_delay_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = LD_CNT_W,
    parameter bit DEASSERT_EN = 1'b1
) (
    input  logic                    clk_core,
    input  logic                    rst_core,
    input  logic [NUM_CH-1:0]       enable,
    input  logic [NUM_CH*CNT_W-1:0] assert_dly,
    input  logic [NUM_CH*CNT_W-1:0] deassert_dly,
    output logic [NUM_CH-1:0]       delayed_en,
    output logic [NUM_CH-1:0]       rise_pulse,
    output logic [NUM_CH-1:0]       fall_pulse,
    output logic [NUM_CH-1:0]       busy
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        level_delay_chan #(
            .CNT_W      (CNT_W),
            .DEASSERT_EN(DEASSERT_EN)
        ) u_chan (
            .clk_core    (clk_core),
            .rst_core    (rst_core),
            .enable      (enable[i]),
            .assert_dly  (assert_dly[i*CNT_W +: CNT_W]),
            .deassert_dly(deassert_dly[i*CNT_W +: CNT_W]),
            .delayed_en  (delayed_en[i]),
            .rise_pulse  (rise_pulse[i]),
            .fall_pulse  (fall_pulse[i]),
            .busy        (busy[i])
        );
    end

endmodule

// File: tb/tb_multi_level_delay.sv
// Scoreboard bench: run-length reference model vs. two DUTs
// (delayed deassert enabled and disabled), directed sequences then random.
module tb_multi_level_delay;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 4;
    localparam int DW     = NUM_CH * CNT_W;

    logic              clk_core = 1'b0;
    logic              rst_core = 1'b1;
    logic [NUM_CH-1:0] enable   = '1;
    logic [DW-1:0]     assert_dly   = '0;
    logic [DW-1:0]     deassert_dly = '0;

    logic [NUM_CH-1:0] den_a, rp_a, fp_a, bsy_a;
    logic [NUM_CH-1:0] den_b, rp_b, fp_b, bsy_b;

    always #5 clk_core = ~clk_core;

    multi_level_delay #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEASSERT_EN(1'b1)) dut (
        .clk_core(clk_core), .rst_core(rst_core), .enable(enable),
        .assert_dly(assert_dly), .deassert_dly(deassert_dly),
        .delayed_en(den_a), .rise_pulse(rp_a), .fall_pulse(fp_a), .busy(bsy_a));

    multi_level_delay #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEASSERT_EN(1'b0)) dut_nd (
        .clk_core(clk_core), .rst_core(rst_core), .enable(enable),
        .assert_dly(assert_dly), .deassert_dly(deassert_dly),
        .delayed_en(den_b), .rise_pulse(rp_b), .fall_pulse(fp_b), .busy(bsy_b));

    typedef struct packed {
        logic [NUM_CH-1:0] den;
        logic [NUM_CH-1:0] rp;
        logic [NUM_CH-1:0] fp;
        logic [NUM_CH-1:0] bsy;
    } obs_t;

    obs_t q_a[$];
    obs_t q_b[$];
    int   checks = 0;
    int   errors = 0;

    // Model: per channel, the output level plus the length of the current run
    // of samples opposing that level. The output flips once the run reaches
    // (delay latched at the start of the run) + 1 samples.
    int run_m [2][NUM_CH];
    int lat_m [2][NUM_CH];
    bit out_m [2][NUM_CH];
    bit rp_m  [2][NUM_CH];
    bit fp_m  [2][NUM_CH];

    task automatic model_reset();
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NUM_CH; c++) begin
                run_m[m][c] = 0; lat_m[m][c] = 0;
                out_m[m][c] = 0; rp_m[m][c] = 0; fp_m[m][c] = 0;
            end
    endtask

    task automatic model_step();
        int ad, dd;
        if (rst_core) begin
            model_reset();
            return;
        end
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < NUM_CH; c++) begin
                ad = int'(assert_dly[c*CNT_W +: CNT_W]);
                dd = (m == 0) ? int'(deassert_dly[c*CNT_W +: CNT_W]) : 0;
                rp_m[m][c] = 0;
                fp_m[m][c] = 0;
                if (out_m[m][c] == enable[c]) begin
                    run_m[m][c] = 0;
                end else begin
                    if (run_m[m][c] == 0) lat_m[m][c] = enable[c] ? ad : dd;
                    run_m[m][c]++;
                    if (run_m[m][c] == lat_m[m][c] + 1) begin
                        out_m[m][c] = enable[c];
                        rp_m[m][c]  = enable[c];
                        fp_m[m][c]  = !enable[c];
                        run_m[m][c] = 0;
                    end
                end
            end
    endtask

    function automatic obs_t model_obs(int m);
        obs_t o;
        for (int c = 0; c < NUM_CH; c++) begin
            o.den[c] = out_m[m][c];
            o.rp[c]  = rp_m[m][c];
            o.fp[c]  = fp_m[m][c];
            o.bsy[c] = run_m[m][c] > 0;
        end
        return o;
    endfunction

    // One cycle: fold the inputs the DUT just sampled into the model, apply
    // the new inputs (reset takes effect at once), queue the expected outputs.
    task automatic cyc(input logic [NUM_CH-1:0] en, input logic [DW-1:0] ad,
                       input logic [DW-1:0] dd, input logic r);
        @(posedge clk_core);
        #1;
        model_step();
        enable = en; assert_dly = ad; deassert_dly = dd; rst_core = r;
        if (r) model_reset();
        q_a.push_back(model_obs(0));
        q_b.push_back(model_obs(1));
    endtask

    task automatic cyc_n(input int n, input logic [NUM_CH-1:0] en, input logic [DW-1:0] ad,
                         input logic [DW-1:0] dd, input logic r);
        for (int i = 0; i < n; i++) cyc(en, ad, dd, r);
    endtask

    task automatic cmp(input string name, input int d, input logic [NUM_CH-1:0] got,
                       input logic [NUM_CH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s dut%0d t=%0t got %b exp %b", name, d, $time, got, exp);
        end
    endtask

    initial begin : monitor
        obs_t e;
        forever begin
            @(negedge clk_core);
            if (q_a.size() > 0) begin
                e = q_a.pop_front();
                cmp("delayed_en", 0, den_a, e.den);
                cmp("rise_pulse", 0, rp_a, e.rp);
                cmp("fall_pulse", 0, fp_a, e.fp);
                cmp("busy", 0, bsy_a, e.bsy);
            end
            if (q_b.size() > 0) begin
                e = q_b.pop_front();
                cmp("delayed_en", 1, den_b, e.den);
                cmp("rise_pulse", 1, rp_b, e.rp);
                cmp("fall_pulse", 1, fp_b, e.fp);
                cmp("busy", 1, bsy_b, e.bsy);
            end
        end
    end

    initial begin : stim
        logic [NUM_CH-1:0] en;
        logic [DW-1:0]     ad, dd;
        logic              r;
        model_reset();
        // Reset held with all enables high.
        cyc_n(3, 4'hF, '0, '0, 1'b1);
        cyc_n(2, 4'h0, '0, '0, 1'b0);
        // ch0 zero assert delay.
        cyc_n(3, 4'b0001, '0, '0, 1'b0);
        // ch1 assert delay 5.
        cyc_n(9, 4'b0011, 16'h0050, '0, 1'b0);
        // ch2 abort: delay 10, enable high 4 cycles.
        cyc_n(4, 4'b0111, 16'h0A50, '0, 1'b0);
        cyc_n(4, 4'b0011, 16'h0A50, '0, 1'b0);
        // ch3 deassert delay 3: glitch of 2, then real fall.
        cyc_n(2, 4'b1011, 16'h0050, 16'h3000, 1'b0);
        cyc_n(2, 4'b0011, 16'h0050, 16'h3000, 1'b0);
        cyc_n(3, 4'b1011, 16'h0050, 16'h3000, 1'b0);
        cyc_n(7, 4'b0011, 16'h0050, 16'h3000, 1'b0);
        // ch2 on-the-fly assert delay change 8 -> 2 mid-count, then reuse 2.
        cyc_n(3, 4'b0111, 16'h0850, '0, 1'b0);
        cyc_n(8, 4'b0111, 16'h0250, '0, 1'b0);
        cyc_n(2, 4'b0011, 16'h0250, '0, 1'b0);
        cyc_n(5, 4'b0111, 16'h0250, '0, 1'b0);
        // Max delay 15 on ch0.
        cyc_n(2, 4'b0110, 16'h025F, '0, 1'b0);
        cyc_n(18, 4'b0111, 16'h025F, 16'h000F, 1'b0);
        cyc_n(18, 4'b0110, 16'h025F, 16'h000F, 1'b0);
        // ch3 deassert 7, reset mid-FALL.
        cyc_n(3, 4'b1111, 16'h0250, 16'h7000, 1'b0);
        cyc_n(3, 4'b0111, 16'h0250, 16'h7000, 1'b0);
        cyc_n(2, 4'b0111, 16'h0250, 16'h7000, 1'b1);
        cyc_n(4, 4'b0111, 16'h0250, 16'h7000, 1'b0);
        // Random traffic: slow enable toggling, delays changing underneath.
        en = enable; ad = assert_dly; dd = deassert_dly;
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                if ($urandom_range(0, 3) == 0) en[c] = ~en[c];
                if ($urandom_range(0, 7) == 0)
                    ad[c*CNT_W +: CNT_W] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 6));
                if ($urandom_range(0, 7) == 0)
                    dd[c*CNT_W +: CNT_W] = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom_range(0, 6));
            end
            r = ($urandom_range(0, 299) == 0);
            cyc(en, ad, dd, r);
        end
        repeat (3) @(negedge clk_core);
        checks++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            errors++;
            $display("FAIL drain left %0d/%0d expected entries", q_a.size(), q_b.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
